// File: rtl/fixed_point_arith_unit_if.sv
// rtl/fixed_point_arith_unit_if.sv - start/busy/done request bus of the fixed-point arithmetic unit
interface fixed_point_arith_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             overflow;
  logic             error;

  modport master (
    output start, operation, operand_1, operand_2,
    input  result, done, busy, overflow, error
  );

  modport slave (
    input  start, operation, operand_1, operand_2,
    output result, done, busy, overflow, error
  );
endinterface

// File: rtl/fixed_point_arith_unit.sv
// rtl/fixed_point_arith_unit.sv - signed Q(WIDTH-FBITS).FBITS ADD/SUB/MUL/DIV/SQRT unit
// MUL, DIV and SQRT are radix-2 engines sharing one shift register and one accumulator.
module fixed_point_arith_unit #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 10,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  fixed_point_arith_unit_if.slave bus
);
  localparam int DW = WIDTH + FBITS;
  localparam int HW = DW / 2;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SQRT = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [DW-1:0]    sh_q, sh_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [HW-1:0]    root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mag_a, mag_b, rem_sub, wrap;
  logic [WIDTH:0]   rem_t, sum;
  logic [PW-1:0]    sq_t, trial, mag_r;
  logic             qbit, neg, big, add_ovf;

  // Magnitude kept unsigned so the most-negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    mag_a   = mag(opa_q);
    mag_b   = mag(opb_q);
    rem_t   = {acc_q[WIDTH-1:0], sh_q[DW-1]};
    qbit    = (rem_t >= {1'b0, mag_b});
    rem_sub = rem_t[WIDTH-1:0] - mag_b;
    sq_t    = {acc_q[PW-3:0], sh_q[DW-1:DW-2]};
    trial   = {{(PW-HW-2){1'b0}}, root_q, 2'b01};
    sum     = (op_q == OP_SUB) ? ({opa_q[WIDTH-1], opa_q} - {opb_q[WIDTH-1], opb_q})
                               : ({opa_q[WIDTH-1], opa_q} + {opb_q[WIDTH-1], opb_q});
    add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    neg     = (op_q != OP_SQRT) && (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
    case (op_q)
      OP_MUL:  mag_r = acc_q >> FBITS;
      OP_DIV:  mag_r = PW'(sh_q);
      default: mag_r = PW'(root_q);
    endcase
    big  = neg ? (mag_r > PW'(MIN_V)) : (mag_r > PW'(MAX_V));
    wrap = neg ? (~mag_r[WIDTH-1:0] + 1'b1) : mag_r[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          op_d    = bus.operation;
          opa_d   = bus.operand_1;
          opb_d   = bus.operand_2;
          acc_d   = '0;
          root_d  = '0;
          sh_d    = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = FINAL;
          case (bus.operation)
            OP_ADD, OP_SUB: bad_d = 1'b0;
            OP_MUL: begin
              sh_d    = DW'(mag(bus.operand_2)) << FBITS;
              cnt_d   = CW'(WIDTH);
              state_d = ITER;
            end
            OP_DIV: begin
              if (bus.operand_2 == '0) begin
                bad_d = 1'b1;
              end else begin
                sh_d    = DW'(mag(bus.operand_1)) << FBITS;
                cnt_d   = CW'(DW);
                state_d = ITER;
              end
            end
            OP_SQRT: begin
              if (bus.operand_1[WIDTH-1]) begin
                bad_d = 1'b1;
              end else begin
                sh_d    = DW'(bus.operand_1) << FBITS;
                cnt_d   = CW'(HW);
                state_d = ITER;
              end
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FINAL;
        case (op_q)
          OP_MUL: begin
            acc_d = (acc_q << 1) + ({PW{sh_q[DW-1]}} & PW'(mag_a));
            sh_d  = sh_q << 1;
          end
          OP_DIV: begin
            // Quotient bits shift in behind the dividend bits they replace.
            acc_d = PW'(qbit ? rem_sub : rem_t[WIDTH-1:0]);
            sh_d  = {sh_q[DW-2:0], qbit};
          end
          default: begin
            if (sq_t >= trial) begin
              acc_d  = sq_t - trial;
              root_d = {root_q[HW-2:0], 1'b1};
            end else begin
              acc_d  = sq_t;
              root_d = {root_q[HW-2:0], 1'b0};
            end
            sh_d = sh_q << 2;
          end
        endcase
      end
      FINAL: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (bad_q) begin
          err_d    = 1'b1;
          ovf_d    = 1'b0;
          result_d = (op_q == OP_DIV) ? (opa_q[WIDTH-1] ? MIN_V : MAX_V) : '0;
        end else if (op_q == OP_ADD || op_q == OP_SUB) begin
          err_d    = 1'b0;
          ovf_d    = add_ovf;
          result_d = (add_ovf && SATURATE) ? (sum[WIDTH] ? MIN_V : MAX_V) : sum[WIDTH-1:0];
        end else begin
          err_d    = 1'b0;
          ovf_d    = big;
          result_d = (big && SATURATE) ? (neg ? MIN_V : MAX_V) : wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign bus.error    = err_q;
endmodule

// File: tb/tb_fixed_point_arith_unit.sv
// tb/tb_fixed_point_arith_unit.sv - vector table and scoreboard bench for fixed_point_arith_unit
module tb_fixed_point_arith_unit;
  localparam int W = 32;
  localparam int F = 10;
  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] MUL  = 3'b010;
  localparam logic [2:0] SQRT = 3'b011;
  localparam logic [2:0] DIV  = 3'b100;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           lat;
  } vec_t;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           t0;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t vecs[$];

  fixed_point_arith_unit_if #(.WIDTH(W)) ifs ();
  fixed_point_arith_unit_if #(.WIDTH(W)) ifw ();

  fixed_point_arith_unit #(.WIDTH(W), .FBITS(F), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(ifs)
  );
  fixed_point_arith_unit #(.WIDTH(W), .FBITS(F), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .bus(ifw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic ovf, input logic err, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.err = err; v.lat = lat;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && ifs.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: result %0h with nothing pending", ifs.result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_result", e.id), 64'(ifs.result), 64'(e.res));
        chk($sformatf("v%0d_overflow", e.id), 64'(ifs.overflow), 64'(e.ovf));
        chk($sformatf("v%0d_error", e.id), 64'(ifs.error), 64'(e.err));
        chk($sformatf("v%0d_latency", e.id), 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  task automatic issue(input vec_t v, input int id);
    exp_t e;
    ifs.start = 1'b1;
    ifs.operation = v.op;
    ifs.operand_1 = v.a;
    ifs.operand_2 = v.b;
    e.id = id; e.res = v.res; e.ovf = v.ovf; e.err = v.err; e.lat = v.lat; e.t0 = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ifs.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < budget; i++) begin
      if (ifs.done === 1'b1) return;
      if (ifs.busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout: no done within %0d cycles", budget);
  endtask

  task automatic run_w(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic ovf, input string nm);
    int n;
    ifw.start = 1'b1;
    ifw.operation = op;
    ifw.operand_1 = a;
    ifw.operand_2 = b;
    @(posedge clk);
    @(negedge clk);
    ifw.start = 1'b0;
    n = 0;
    while (ifw.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 64'(ifw.done), 64'd1);
    chk({nm, "_result"}, 64'(ifw.result), 64'(res));
    chk({nm, "_overflow"}, 64'(ifw.overflow), 64'(ovf));
    chk({nm, "_error"}, 64'(ifw.error), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    int pulses;
    reset = 1'b0;
    ifs.start = 1'b0; ifs.operation = '0; ifs.operand_1 = '0; ifs.operand_2 = '0;
    ifw.start = 1'b0; ifw.operation = '0; ifw.operand_1 = '0; ifw.operand_2 = '0;

    vecs.push_back(mk(MUL,  32'h00000600, 32'h00000900, 32'h00000D80, 1'b0, 1'b0, 33));
    vecs.push_back(mk(MUL,  32'hFFFFFA00, 32'h00000900, 32'hFFFFF280, 1'b0, 1'b0, 33));
    vecs.push_back(mk(SQRT, 32'h00000900, 32'h00000000, 32'h00000600, 1'b0, 1'b0, 22));
    vecs.push_back(mk(SQRT, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 22));
    vecs.push_back(mk(SQRT, 32'hFFFFFC00, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(DIV,  32'h00000D80, 32'h00000600, 32'h00000900, 1'b0, 1'b0, 43));
    vecs.push_back(mk(DIV,  32'h00000400, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1));
    vecs.push_back(mk(DIV,  32'hFFFFFC00, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(ADD,  32'h7FFFFFFF, 32'h00000400, 32'h7FFFFFFF, 1'b1, 1'b0, 1));
    vecs.push_back(mk(SUB,  32'h80000000, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1));
    vecs.push_back(mk(MUL,  32'h7FFFFFFF, 32'h00000800, 32'h7FFFFFFF, 1'b1, 1'b0, 33));
    vecs.push_back(mk(3'b111, 32'h00000123, 32'h00000456, 32'h00000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(ADD,  32'h00000400, 32'h00000600, 32'h00000A00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(SUB,  32'h00000400, 32'h00000600, 32'hFFFFFE00, 1'b0, 1'b0, 1));
    vecs.push_back(mk(MUL,  32'h80000000, 32'h00000400, 32'h80000000, 1'b0, 1'b0, 33));
    vecs.push_back(mk(MUL,  32'h80000000, 32'hFFFFFC00, 32'h7FFFFFFF, 1'b1, 1'b0, 33));
    vecs.push_back(mk(DIV,  32'h80000000, 32'h00000400, 32'h80000000, 1'b0, 1'b0, 43));
    vecs.push_back(mk(DIV,  32'hFFFFF280, 32'h00000600, 32'hFFFFF700, 1'b0, 1'b0, 43));
    vecs.push_back(mk(DIV,  32'h00000400, 32'h00000C00, 32'h00000155, 1'b0, 1'b0, 43));
    vecs.push_back(mk(DIV,  32'hFFFFFC00, 32'h00000C00, 32'hFFFFFEAB, 1'b0, 1'b0, 43));
    vecs.push_back(mk(SQRT, 32'h00000800, 32'h00000000, 32'h000005A8, 1'b0, 1'b0, 22));
    vecs.push_back(mk(SQRT, 32'h7FFFFFFF, 32'h00000000, 32'h0016A09E, 1'b0, 1'b0, 22));
    vecs.push_back(mk(MUL,  32'hFFFFFFFF, 32'h00000200, 32'h00000000, 1'b0, 1'b0, 33));
    vecs.push_back(mk(DIV,  32'h7FFFFFFF, 32'h00000200, 32'h7FFFFFFF, 1'b1, 1'b0, 43));
    vecs.push_back(mk(3'b101, 32'h00000400, 32'h00000400, 32'h00000000, 1'b0, 1'b1, 1));

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(ifs.busy), 64'd0);
    chk("reset_done", 64'(ifs.done), 64'd0);
    chk("reset_result", 64'(ifs.result), 64'd0);
    chk("reset_overflow", 64'(ifs.overflow), 64'd0);
    chk("reset_error", 64'(ifs.error), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Each vector after the first is issued in the previous operation's done cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i], i);
      wait_done(200, nb);
      chk($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'(vecs[i].lat));
    end

    issue(mk(MUL, 32'h00000600, 32'h00000900, 32'h00000D80, 1'b0, 1'b0, 33), 100);
    for (int k = 0; k < 3; k++) begin
      ifs.start = 1'b1;
      ifs.operation = ADD;
      ifs.operand_1 = $urandom;
      ifs.operand_2 = $urandom;
      @(negedge clk);
      chk("ignored_start_busy", 64'(ifs.busy), 64'd1);
    end
    ifs.start = 1'b0;
    wait_done(200, nb);

    issue(mk(DIV, 32'h00000D80, 32'h00000600, 32'h00000900, 1'b0, 1'b0, 43), 101);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("abort_busy", 64'(ifs.busy), 64'd0);
    chk("abort_done", 64'(ifs.done), 64'd0);
    chk("abort_result", 64'(ifs.result), 64'd0);
    chk("abort_overflow", 64'(ifs.overflow), 64'd0);
    chk("abort_error", 64'(ifs.error), 64'd0);

    ifs.start = 1'b1;
    ifs.operation = ADD;
    ifs.operand_1 = 32'h00000400;
    ifs.operand_2 = 32'h00000400;
    @(negedge clk);
    reset = 1'b1;
    ifs.start = 1'b0;
    @(negedge clk);
    chk("reset_start_busy", 64'(ifs.busy), 64'd0);
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifs.done === 1'b1) pulses++;
    end
    chk("no_done_after_reset", 64'(pulses), 64'd0);

    issue(mk(MUL, 32'hFFFFFA00, 32'hFFFFF700, 32'h00000D80, 1'b0, 1'b0, 33), 102);
    wait_done(200, nb);
    chk("post_reset_mul_busy_cycles", 64'(nb), 64'd33);

    run_w(ADD, 32'h7FFFFFFF, 32'h00000400, 32'h800003FF, 1'b1, "wrap_add");
    run_w(MUL, 32'h7FFFFFFF, 32'h00000800, 32'hFFFFFFFE, 1'b1, "wrap_mul");
    run_w(MUL, 32'h80000000, 32'hFFFFFC00, 32'h80000000, 1'b1, "wrap_mul_minneg");
    run_w(DIV, 32'h7FFFFFFF, 32'h00000200, 32'hFFFFFFFE, 1'b1, "wrap_div");

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fixed_point_arith_unit.md
Name: fixed_point_arith_unit

Overview:
Parametrised signed fixed-point arithmetic unit. Format is two's-complement Q(WIDTH-FBITS).FBITS. Supports ADD, SUB, MUL, DIV and SQRT behind a start/busy/done handshake, with optional saturation and overflow/error flags. It sits beside the integer execute stage and serves the FPU opcodes. MUL, DIV and SQRT are iterative radix-2 engines whose latency scales with the parameters.

Parameters:
WIDTH, 32, operand/result width in bits; WIDTH+FBITS must be even.
FBITS, 10, fractional bits.
SATURATE, 1, 1 = clamp on overflow; 0 = wrap (keep low WIDTH bits).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  request; accepted only when busy=0.
operation  in  3  000 ADD, 001 SUB, 010 MUL, 011 SQRT, 100 DIV; others are invalid.
operand_1  in  WIDTH  signed operand A (dividend / radicand).
operand_2  in  WIDTH  signed operand B (ignored by SQRT).
result  out  WIDTH  signed result; held until the next done.
done  out  1  one-cycle pulse when result and flags update.
busy  out  1  high from the accepting edge until the edge that raises done.
overflow  out  1  result out of range (clamped or wrapped).
error  out  1  divide-by-zero, negative SQRT, or invalid opcode.

Behaviour:
- Reset: reset=0 at an edge forces IDLE, busy=0, done=0, result=0, overflow=0, error=0, and clears internal counters. Reset wins over start. Reset mid-operation aborts the operation and no done is issued.
- FSM states: IDLE, ITER, FINAL.
  - IDLE: on start=1, latch operation and operands, then go to ITER (MUL/DIV/SQRT) or FINAL (ADD/SUB/invalid/negative SQRT/DIV by zero); busy=1.
  - ITER: one iteration per cycle; go to FINAL after the last iteration.
  - FINAL: write result/flags, pulse done, clear busy, return to IDLE.
- start while busy=1 is ignored. Operand changes after acceptance have no effect.
- A new start in the done cycle is accepted, since busy is already 0.
- Latency (accepting edge to done visible): ADD/SUB 1; MUL WIDTH+1; SQRT (WIDTH+FBITS)/2+1; DIV WIDTH+FBITS+1; error cases 1. Defaults: 1/33/22/43.
- ADD/SUB: WIDTH+1-bit exact sum; overflow if it is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- MUL: shift-add on magnitudes, 2*WIDTH-bit product, shift right by FBITS (truncate toward zero), then apply sign = sign(A) xor sign(B).
- DIV: restoring division of (|A|<<FBITS) by |B| over WIDTH+FBITS bits; truncate toward zero; sign as MUL.
  - B=0: error=1, overflow=0, result = 2^(WIDTH-1)-1 if A>=0, else -2^(WIDTH-1).
- SQRT: digit-by-digit root of A<<FBITS, (WIDTH+FBITS)/2 iterations; result = floor(sqrt(A*2^FBITS)), non-negative. A<0: error=1, result=0.
- Range check (MUL/DIV): signed result overflows if positive magnitude > 2^(WIDTH-1)-1 or negative magnitude > 2^(WIDTH-1).
  - SATURATE=1: result clamps to 0x7FF..F or 0x800..0.
  - SATURATE=0: result = low WIDTH bits of the signed value.
  - overflow=1 in either mode.
- Most-negative operand: magnitude 2^(WIDTH-1) must be handled exactly, with no sign loss.
- Invalid opcode: result=0, error=1, overflow=0.
- Flags and result change only in the done cycle and hold between operations.

Test Plan:
(defaults WIDTH 32, FBITS 10)
- MUL 0x00000600 (1.5) x 0x00000900 (2.25) -> result 0x00000D80, done exactly 33 cycles after the accepting edge, busy high for 33 cycles, flags 0. Then -1.5 (0xFFFFFA00) x 2.25 -> 0xFFFFF280.
- SQRT 0x00000900 -> 0x00000600 at cycle 22; SQRT 0x00000000 -> 0. SQRT 0xFFFFFC00 -> result 0, error=1, done at cycle 1.
- DIV 0x00000D80 / 0x00000600 -> 0x00000900 at cycle 43. DIV 0x00000400 / 0 -> 0x7FFFFFFF, error=1. DIV 0xFFFFFC00 / 0 -> 0x80000000, error=1.
- ADD 0x7FFFFFFF + 0x00000400 -> SATURATE=1: 0x7FFFFFFF, overflow=1; SATURATE=0: 0x800003FF, overflow=1. SUB 0x80000000 - 0x00000001 -> 0x80000000, overflow=1. MUL 0x7FFFFFFF x 0x00000800 -> 0x7FFFFFFF, overflow=1.
- Handshake: a second start during a MUL is ignored, with operands changed mid-run (result still 0x00000D80). Back-to-back ADD issued in the done cycle is accepted. Opcode 111 -> error=1, result 0.
- Reset: drive reset=0 at cycle 10 of a DIV -> next cycle busy=0, done never pulses, outputs 0. Reset=0 together with start -> no acceptance. A fresh MUL after reset returns correct results.
